// File: rtl/axi_grid_router.sv
// Five-port wormhole router for one torus node: per-input FIFOs, XY shortest-path routing
// with wrap-around, and per-output round-robin arbitration with packet-level locking.
module axi_grid_router #(
  parameter int unsigned NUM_ROW    = 3,
  parameter int unsigned NUM_COL    = 3,
  parameter int unsigned NODE_H     = 0,
  parameter int unsigned NODE_V     = 0,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned HW   = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1,
  localparam int unsigned VW   = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  localparam int unsigned ID_W = HW + VW
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [4:0]             in_valid_i,
  output logic [4:0]             in_ready_o,
  input  logic [4:0][ID_W-1:0]   in_dst_i,
  input  logic [4:0]             in_last_i,
  input  logic [4:0][DATA_W-1:0] in_data_i,
  output logic [4:0]             out_valid_o,
  input  logic [4:0]             out_ready_i,
  output logic [4:0][ID_W-1:0]   out_dst_o,
  output logic [4:0]             out_last_o,
  output logic [4:0][DATA_W-1:0] out_data_o,
  output logic                   err_o
);

  localparam int unsigned NP = 5;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = ID_W + 1 + DATA_W;

  localparam logic [HW:0] RowN    = (HW+1)'(NUM_ROW);
  localparam logic [HW:0] RowHalf = (HW+1)'(NUM_ROW / 2);
  localparam logic [HW:0] NodeH   = (HW+1)'(NODE_H);
  localparam logic [VW:0] ColN    = (VW+1)'(NUM_COL);
  localparam logic [VW:0] ColHalf = (VW+1)'(NUM_COL / 2);
  localparam logic [VW:0] NodeV   = (VW+1)'(NODE_V);

  typedef logic [2:0] port_t;
  typedef enum logic {StIdle, StLocked} arb_st_e;

  function automatic logic dst_bad_f(input logic [ID_W-1:0] dst);
    return ({1'b0, dst[ID_W-1:VW]} >= RowN) || ({1'b0, dst[VW-1:0]} >= ColN);
  endfunction

  // Output index: 0 local, 1 east, 2 west, 3 north, 4 south; ties go east/south.
  function automatic port_t route_f(input logic [ID_W-1:0] dst);
    logic [HW:0] h, dh;
    logic [VW:0] v, dv;
    port_t       r;
    h  = {1'b0, dst[ID_W-1:VW]};
    v  = {1'b0, dst[VW-1:0]};
    dh = (h >= NodeH) ? h - NodeH : h + RowN - NodeH;
    dv = (v >= NodeV) ? v - NodeV : v + ColN - NodeV;
    if (dst_bad_f(dst))  r = 3'd0;
    else if (dv != '0)   r = (dv <= ColHalf) ? 3'd1 : 3'd2;
    else if (dh != '0)   r = (dh <= RowHalf) ? 3'd4 : 3'd3;
    else                 r = 3'd0;
    return r;
  endfunction

  logic [EW-1:0]            mem_q [NP][FIFO_DEPTH];
  logic [PW-1:0]            wptr_q [NP];
  logic [PW-1:0]            rptr_q [NP];
  logic [CW-1:0]            cnt_q [NP];
  logic [NP-1:0]            push, pop, empty, full, midpkt_q, in_pkt_q;
  port_t                    route_q [NP];
  port_t                    cur_route [NP];
  logic [NP-1:0][ID_W-1:0]  head_dst;
  logic [NP-1:0]            head_last;
  logic [NP-1:0][DATA_W-1:0] head_data;
  logic                     err_q, err_d;

  arb_st_e       state_q [NP];
  arb_st_e       state_d [NP];
  port_t         lock_src_q [NP], lock_src_d [NP];
  port_t         rr_q [NP], rr_d [NP];
  port_t         hold_src_q [NP], hold_src_d [NP];
  port_t         gnt [NP];
  logic [NP-1:0] hold_q, hold_d, vld, xfer;
  logic [NP-1:0] req [NP];

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      empty[i]      = (cnt_q[i] == '0);
      full[i]       = (cnt_q[i] == CW'(FIFO_DEPTH));
      in_ready_o[i] = ~full[i] & ~arst_i;
      push[i]       = in_valid_i[i] & in_ready_o[i];
      {head_dst[i], head_last[i], head_data[i]} = mem_q[i][rptr_q[i]];
      cur_route[i]  = midpkt_q[i] ? route_q[i] : route_f(head_dst[i]);
    end
  end

  // Range errors are flagged when a head flit enters, so body flits never re-raise them.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NP; i++) begin
      if (push[i] && !in_pkt_q[i] && dst_bad_f(in_dst_i[i])) err_d = 1'b1;
    end
  end
  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NP; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= {in_dst_i[i], in_last_i[i], in_data_i[i]};
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NP; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        cnt_q[i]   <= '0;
        route_q[i] <= '0;
      end
      midpkt_q <= '0;
      in_pkt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (push[i]) begin
          wptr_q[i]   <= wptr_q[i] + PW'(1);
          in_pkt_q[i] <= ~in_last_i[i];
        end
        if (pop[i]) begin
          rptr_q[i]   <= rptr_q[i] + PW'(1);
          midpkt_q[i] <= ~head_last[i];
          route_q[i]  <= cur_route[i];
        end
        if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + CW'(1);
        else if (pop[i] && !push[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
      end
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int o = 0; o < NP; o++) begin
        state_q[o]    <= StIdle;
        lock_src_q[o] <= '0;
        rr_q[o]       <= '0;
        hold_src_q[o] <= '0;
      end
      hold_q <= '0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        state_q[o]    <= state_d[o];
        lock_src_q[o] <= lock_src_d[o];
        rr_q[o]       <= rr_d[o];
        hold_src_q[o] <= hold_src_d[o];
      end
      hold_q <= hold_d;
    end
  end

  // Grant: locked source, else a frozen grant while stalled, else round-robin from rr_q.
  always_comb begin
    logic       found;
    logic [3:0] sum;
    port_t      idx;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) req[o][i] = ~empty[i] & (cur_route[i] == port_t'(o));
    end
    for (int o = 0; o < NP; o++) begin
      gnt[o] = '0;
      found  = 1'b0;
      if (state_q[o] == StLocked) begin
        gnt[o] = lock_src_q[o];
      end else if (hold_q[o]) begin
        gnt[o] = hold_src_q[o];
      end else begin
        for (int k = 0; k < NP; k++) begin
          sum = {1'b0, rr_q[o]} + 4'(k);
          if (sum >= 4'(NP)) sum = sum - 4'(NP);
          idx = sum[2:0];
          if (!found && req[o][idx]) begin
            gnt[o] = idx;
            found  = 1'b1;
          end
        end
      end
      vld[o]         = req[o][gnt[o]];
      xfer[o]        = vld[o] & out_ready_i[o];
      out_valid_o[o] = vld[o];
      out_dst_o[o]   = vld[o] ? head_dst[gnt[o]] : '0;
      out_last_o[o]  = vld[o] & head_last[gnt[o]];
      out_data_o[o]  = vld[o] ? head_data[gnt[o]] : '0;
    end
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < NP; o++) begin
      state_d[o]    = state_q[o];
      lock_src_d[o] = lock_src_q[o];
      rr_d[o]       = rr_q[o];
      hold_d[o]     = vld[o] & ~out_ready_i[o];
      hold_src_d[o] = gnt[o];
      if (xfer[o]) begin
        pop[gnt[o]]   = 1'b1;
        lock_src_d[o] = gnt[o];
        state_d[o]    = head_last[gnt[o]] ? StIdle : StLocked;
        if (state_q[o] == StIdle) rr_d[o] = (gnt[o] == 3'd4) ? 3'd0 : gnt[o] + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_grid_router.sv
// Directed bench for axi_grid_router on a 3x3 torus at node (0,0): a per-output expected-flit
// scoreboard driven by a plain-arithmetic routing model, plus hand-computed literal checks.
module tb_axi_grid_router;

  localparam int NR  = 3;
  localparam int NC  = 3;
  localparam int NH  = 0;
  localparam int NV  = 0;
  localparam int DW  = 64;
  localparam int IDW = 4;
  localparam int FW  = IDW + 1 + DW;

  logic                  clk = 1'b0;
  logic                  arst_i = 1'b1;
  logic [4:0]            in_valid_i = '0;
  logic [4:0]            in_ready_o;
  logic [4:0][IDW-1:0]   in_dst_i = '0;
  logic [4:0]            in_last_i = '0;
  logic [4:0][DW-1:0]    in_data_i = '0;
  logic [4:0]            out_valid_o;
  logic [4:0]            out_ready_i = '1;
  logic [4:0][IDW-1:0]   out_dst_o;
  logic [4:0]            out_last_o;
  logic [4:0][DW-1:0]    out_data_o;
  logic                  err_o;

  always #5 clk = ~clk;

  axi_grid_router #(
    .NUM_ROW   (NR),
    .NUM_COL   (NC),
    .NODE_H    (NH),
    .NODE_V    (NV),
    .DATA_W    (DW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i      (clk),
    .arst_i     (arst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_dst_i   (in_dst_i),
    .in_last_i  (in_last_i),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_dst_o  (out_dst_o),
    .out_last_o (out_last_o),
    .out_data_o (out_data_o),
    .err_o      (err_o)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [FW-1:0] exp_q [5][$];
  logic [4:0]    prev_stall = '0;
  logic [FW-1:0] prev_flit [5];

  task automatic check(input string name, input logic [FW-1:0] got, input logic [FW-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Shortest-path XY on the torus, straight from the routing rules.
  function automatic int model_route(input logic [IDW-1:0] d);
    int h, v, dv, dh;
    h = int'(d[3:2]);
    v = int'(d[1:0]);
    if (h >= NR || v >= NC) return 0;
    dv = (v - NV + NC) % NC;
    dh = (h - NH + NR) % NR;
    if (dv != 0) return (dv <= NC / 2) ? 1 : 2;
    if (dh != 0) return (dh <= NR / 2) ? 4 : 3;
    return 0;
  endfunction

  function automatic void expect_flit(input int o, input logic [IDW-1:0] d, input logic l,
                                      input logic [DW-1:0] x);
    exp_q[o].push_back({d, l, x});
  endfunction

  function automatic void expect_routed(input logic [IDW-1:0] d, input logic l,
                                        input logic [DW-1:0] x);
    expect_flit(model_route(d), d, l, x);
  endfunction

  function automatic int pending();
    int s = 0;
    for (int o = 0; o < 5; o++) s += exp_q[o].size();
    return s;
  endfunction

  // Scoreboard: every accepted flit must be the next one expected on that output, and a
  // stalled output must hold its flit unchanged.
  always @(negedge clk) begin
    logic [FW-1:0] cur;
    if (arst_i) begin
      prev_stall = '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        cur = {out_dst_o[o], out_last_o[o], out_data_o[o]};
        if (prev_stall[o]) begin
          check($sformatf("out%0d_hold_valid", o), FW'(out_valid_o[o]), FW'(1));
          check($sformatf("out%0d_hold_flit", o), cur, prev_flit[o]);
        end
        if (out_valid_o[o] && out_ready_i[o]) begin
          if (exp_q[o].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out%0d_unexpected: got 0x%0h, want no flit", o, cur);
          end else begin
            check($sformatf("out%0d_flit", o), cur, exp_q[o].pop_front());
          end
        end
        prev_stall[o] = out_valid_o[o] & ~out_ready_i[o];
        prev_flit[o]  = cur;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [IDW-1:0] d, input logic l,
                       input logic [DW-1:0] x);
    in_valid_i[p] = v;
    in_dst_i[p]   = d;
    in_last_i[p]  = l;
    in_data_i[p]  = x;
  endtask

  task automatic do_reset();
    in_valid_i  = '0;
    out_ready_i = '1;
    arst_i      = 1'b1;
    for (int o = 0; o < 5; o++) exp_q[o].delete();
    repeat (2) @(posedge clk);
    #1;
    arst_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 40 && pending() != 0; n++) step();
    for (int o = 0; o < 5; o++)
      check($sformatf("%s_left_out%0d", tag, o), FW'(exp_q[o].size()), FW'(0));
  endtask

  logic [IDW-1:0] t1_dst  [4] = '{4'b0010, 4'b0001, 4'b1000, 4'b0000};
  int             t1_port [4] = '{2, 1, 3, 0};
  logic [DW-1:0]  t1_data [4] = '{64'hA5, 64'hB1, 64'hC3, 64'hD0};

  initial begin
    #2;
    check("rst_in_ready", FW'(in_ready_o), FW'(0));
    check("rst_out_valid", FW'(out_valid_o), FW'(0));
    check("rst_out_data", FW'(|out_data_o), FW'(0));
    check("rst_err", FW'(err_o), FW'(0));
    @(posedge clk);
    #1;
    arst_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready", FW'(in_ready_o), FW'(5'h1f));
    step();

    // Single-flit routing from the local port, one destination at a time.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, t1_dst[k], 1'b1, t1_data[k]);
      expect_routed(t1_dst[k], 1'b1, t1_data[k]);
      @(negedge clk);
      step();
      drive(0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      check($sformatf("t1_valid_%0d", k), FW'(out_valid_o), FW'(5'd1 << t1_port[k]));
      check($sformatf("t1_data_%0d", k), FW'(out_data_o[t1_port[k]]), FW'(t1_data[k]));
      step();
    end
    drain("t1");

    // Two 3-flit packets to local: no interleave, then round-robin resumes after input 3.
    do_reset();
    for (int k = 0; k < 3; k++) expect_flit(0, 4'b0000, k == 2, 64'(16 + k));
    for (int k = 0; k < 3; k++) expect_flit(0, 4'b0000, k == 2, 64'(48 + k));
    for (int k = 0; k < 3; k++) begin
      drive(1, 1'b1, 4'b0000, k == 2, 64'(16 + k));
      drive(3, 1'b1, 4'b0000, k == 2, 64'(48 + k));
      @(negedge clk);
      if (k == 1) check("t2_first_beat", FW'(out_data_o[0]), FW'(64'h10));
      step();
    end
    drive(1, 1'b0, '0, 1'b0, '0);
    drive(3, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    step();
    @(negedge clk);
    check("t2_second_pkt", FW'(out_data_o[0]), FW'(64'h30));
    drain("t2a");
    expect_flit(0, 4'b0000, 1'b1, 64'h4A);
    expect_flit(0, 4'b0000, 1'b1, 64'h0A);
    drive(4, 1'b1, 4'b0000, 1'b1, 64'h4A);
    drive(0, 1'b1, 4'b0000, 1'b1, 64'h0A);
    @(negedge clk);
    step();
    drive(4, 1'b0, '0, 1'b0, '0);
    drive(0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check("t2_rr_next", FW'(out_data_o[0]), FW'(64'h4A));
    step();
    drain("t2b");

    // Locked packet with a 2-cycle bubble; input 3 must wait.
    do_reset();
    expect_flit(0, 4'b0000, 1'b0, 64'h100);
    expect_flit(0, 4'b0000, 1'b0, 64'h101);
    expect_flit(0, 4'b0000, 1'b1, 64'h102);
    expect_flit(0, 4'b0000, 1'b1, 64'h300);
    drive(1, 1'b1, 4'b0000, 1'b0, 64'h100);
    drive(3, 1'b1, 4'b0000, 1'b1, 64'h300);
    @(negedge clk);
    step();
    drive(1, 1'b0, '0, 1'b0, '0);
    drive(3, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check("t3_head", FW'(out_data_o[0]), FW'(64'h100));
    step();
    @(negedge clk);
    check("t3_gap1_valid", FW'(out_valid_o[0]), FW'(0));
    step();
    drive(1, 1'b1, 4'b0000, 1'b0, 64'h101);
    @(negedge clk);
    check("t3_gap2_valid", FW'(out_valid_o[0]), FW'(0));
    step();
    drive(1, 1'b1, 4'b0000, 1'b1, 64'h102);
    @(negedge clk);
    check("t3_resume", FW'(out_data_o[0]), FW'(64'h101));
    step();
    drive(1, 1'b0, '0, 1'b0, '0);
    drain("t3");

    // FIFO fill with a blocked output, then same-cycle pop while full.
    do_reset();
    out_ready_i[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 4'b0000, 1'b1, 64'(512 + k));
      expect_flit(0, 4'b0000, 1'b1, 64'(512 + k));
      @(negedge clk);
      check($sformatf("t4_ready_%0d", k), FW'(in_ready_o[0]), FW'(1));
      step();
    end
    drive(0, 1'b1, 4'b0000, 1'b1, 64'h204);
    expect_flit(0, 4'b0000, 1'b1, 64'h204);
    @(negedge clk);
    check("t4_full", FW'(in_ready_o[0]), FW'(0));
    check("t4_head_held", FW'(out_data_o[0]), FW'(64'h200));
    step();
    out_ready_i[0] = 1'b1;
    @(negedge clk);
    check("t4_pop_cycle_ready", FW'(in_ready_o[0]), FW'(0));
    step();
    @(negedge clk);
    check("t4_ready_back", FW'(in_ready_o[0]), FW'(1));
    step();
    drive(0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check("t4_ready_stays", FW'(in_ready_o[0]), FW'(1));
    step();
    drain("t4");

    // Out-of-range destination: sticky error, delivered locally.
    do_reset();
    drive(0, 1'b1, 4'b1100, 1'b1, 64'h55);
    expect_flit(0, 4'b1100, 1'b1, 64'h55);
    @(negedge clk);
    check("t5_err_before", FW'(err_o), FW'(0));
    step();
    drive(0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check("t5_err_set", FW'(err_o), FW'(1));
    check("t5_port0_valid", FW'(out_valid_o), FW'(5'b00001));
    check("t5_port0_data", FW'(out_data_o[0]), FW'(64'h55));
    step();
    drive(0, 1'b1, 4'b0001, 1'b1, 64'h56);
    expect_routed(4'b0001, 1'b1, 64'h56);
    @(negedge clk);
    step();
    drive(0, 1'b0, '0, 1'b0, '0);
    drain("t5");
    @(negedge clk);
    check("t5_err_sticky", FW'(err_o), FW'(1));
    step();

    // Reset mid-packet with two flits buffered.
    do_reset();
    @(negedge clk);
    check("t6_err_cleared", FW'(err_o), FW'(0));
    step();
    out_ready_i[0] = 1'b0;
    drive(1, 1'b1, 4'b0000, 1'b0, 64'h600);
    @(negedge clk);
    step();
    drive(1, 1'b1, 4'b0000, 1'b0, 64'h601);
    @(negedge clk);
    step();
    drive(1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check("t6_valid_before", FW'(out_valid_o[0]), FW'(1));
    step();
    arst_i = 1'b1;
    #1;
    check("t6_valid_in_rst", FW'(out_valid_o), FW'(0));
    check("t6_ready_in_rst", FW'(in_ready_o), FW'(0));
    check("t6_data_in_rst", FW'(|out_data_o), FW'(0));
    repeat (2) @(posedge clk);
    #1;
    arst_i      = 1'b0;
    out_ready_i = '1;
    @(negedge clk);
    check("t6_ready_after", FW'(in_ready_o), FW'(5'h1f));
    check("t6_empty_after", FW'(out_valid_o), FW'(0));
    step();
    drive(3, 1'b1, 4'b0000, 1'b1, 64'h63);
    drive(1, 1'b1, 4'b0001, 1'b1, 64'h61);
    expect_routed(4'b0000, 1'b1, 64'h63);
    expect_routed(4'b0001, 1'b1, 64'h61);
    @(negedge clk);
    step();
    drive(3, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check("t6_new_pkt", FW'(out_data_o[0]), FW'(64'h63));
    check("t6_parallel", FW'(out_valid_o), FW'(5'b00011));
    step();
    drain("t6");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
